ps2_move_decoder: RTL and testbench

PS2_MOVE_DECODER -- requirements
Module: ps2_move_decoder

---
 rtl/ps2_move_decoder_pkg.sv | 67 ++++++
 rtl/ps2_frame_rx.sv | 126 ++++++++++++
 rtl/ps2_move_decoder.sv | 86 ++++++++
 tb/tb_ps2_move_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_move_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_move_decoder_pkg
// Shared definitions for the PS/2 keyboard move decoder: keyboard scan-code
// constants, the move command encoding, the frame receiver state type and a
// helper that maps a make code to a move command.
// ---------------------------------------------------------------------------
package ps2_move_decoder_pkg;

   // Prefix bytes sent by the keyboard ahead of extended keys and releases
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   // Extended (arrow) key codes, valid only after an SC_EXT prefix
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_UP    = 8'h75;

   // Plain key code for the space bar
   localparam logic [7:0] SC_SPACE = 8'h29;

   // Move command encoding presented on the cmd port
   typedef enum logic [1:0] {
      CMD_LEFT   = 2'd0,
      CMD_RIGHT  = 2'd1,
      CMD_DOWN   = 2'd2,
      CMD_ROTATE = 2'd3
   } move_cmd_t;

   // Frame receiver states: waiting for a start bit, shifting the eight data
   // bits, taking the parity bit, then checking the stop bit
   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_t;

   // Result of looking up one make code
   typedef struct packed {
      logic      valid;
      move_cmd_t cmd;
   } move_hit_t;

   // Maps a make code to a move command. Arrow keys only count when they were
   // preceded by the extended prefix; the space bar only counts without it.
   function automatic move_hit_t decode_move(input logic [7:0] code,
                                             input logic       ext);
      move_hit_t hit;
      hit.valid = 1'b0;
      hit.cmd   = CMD_LEFT;
      if (ext) begin
         case (code)
            SC_LEFT:  begin hit.valid = 1'b1; hit.cmd = CMD_LEFT;   end
            SC_RIGHT: begin hit.valid = 1'b1; hit.cmd = CMD_RIGHT;  end
            SC_DOWN:  begin hit.valid = 1'b1; hit.cmd = CMD_DOWN;   end
            SC_UP:    begin hit.valid = 1'b1; hit.cmd = CMD_ROTATE; end
            default:  hit.valid = 1'b0;
         endcase
      end else if (code == SC_SPACE) begin
         hit.valid = 1'b1;
         hit.cmd   = CMD_ROTATE;
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop)
// from the raw keyboard clock/data lines.
//
// Ports:
//   clk        in   system clock
//   resetn     in   synchronous active-low reset
//   ps2_clk    in   raw keyboard clock (asynchronous)
//   ps2_data   in   raw keyboard data (asynchronous)
//   byte_valid out  one-cycle pulse, a good byte is now in scan_code
//   scan_code  out  last good byte, held until the next good byte
//   frame_err  out  one-cycle pulse on parity error, bad stop bit or timeout
// ---------------------------------------------------------------------------
module ps2_frame_rx
   import ps2_move_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] scan_code,
   output logic       frame_err
);

   localparam int              CW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_prev;
   logic          fall;
   rx_state_t     state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          parity_ok;
   logic [CW-1:0] idle_cnt;

   // Two-flop synchronizers for both keyboard lines plus a delayed copy of
   // the synchronized clock for edge detection. Reset loads the idle bus
   // level so that leaving reset never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
      end
   end

   // The keyboard changes data while its clock is high, so the falling edge
   // is the moment the data line is stable and can be sampled.
   assign fall = clk_prev & ~clk_sync[1];

   // Frame FSM with the idle timeout folded in. Every state change and data
   // sample happens on a detected falling edge; the only exception is the
   // timeout, which fires when a frame in progress sees no edge for
   // TIMEOUT_CYCLES cycles. Timeout and stop-bit handling cannot coincide
   // because the timeout branch requires the absence of an edge, so
   // byte_valid and frame_err are mutually exclusive by construction.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= RX_IDLE;
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'h00;
         parity_ok  <= 1'b0;
         idle_cnt   <= '0;
         scan_code  <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (state == RX_IDLE || fall) begin
            idle_cnt <= '0;
         end else if (idle_cnt == TIMEOUT_LAST) begin
            idle_cnt  <= '0;
            state     <= RX_IDLE;
            frame_err <= 1'b1;
         end else begin
            idle_cnt <= idle_cnt + CW'(1);
         end

         if (fall) begin
            case (state)
               RX_IDLE: begin
                  if (!data_sync[1]) begin
                     state   <= RX_DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               RX_DATA: begin
                  shift_reg <= {data_sync[1], shift_reg[7:1]};
                  if (bit_cnt == 3'd7) begin
                     state <= RX_PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               RX_PARITY: begin
                  parity_ok <= ^{shift_reg, data_sync[1]};
                  state     <= RX_STOP;
               end
               RX_STOP: begin
                  if (data_sync[1] && parity_ok) begin
                     byte_valid <= 1'b1;
                     scan_code  <= shift_reg;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= RX_IDLE;
               end
               default: state <= RX_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_move_decoder.sv
// ---------------------------------------------------------------------------
// ps2_move_decoder
// Turns PS/2 keyboard traffic into game move commands. The frame receiver
// delivers bytes; this level tracks the E0/F0 prefixes and emits a command
// for the arrow keys (extended) and the space bar.
//
// Ports:
//   clk        in   system clock
//   resetn     in   synchronous active-low reset
//   ps2_clk    in   raw keyboard clock (asynchronous)
//   ps2_data   in   raw keyboard data (asynchronous)
//   byte_valid out  one-cycle pulse, a good byte is now in scan_code
//   scan_code  out  last good byte, held until the next good byte
//   cmd_valid  out  one-cycle pulse, a move command is now in cmd
//   cmd        out  0 left, 1 right, 2 down, 3 rotate; held until next pulse
//   frame_err  out  one-cycle pulse on parity error, bad stop bit or timeout
// ---------------------------------------------------------------------------
module ps2_move_decoder
   import ps2_move_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] scan_code,
   output logic       cmd_valid,
   output logic [1:0] cmd,
   output logic       frame_err
);

   logic      ext_pending;
   logic      brk_pending;
   move_hit_t hit;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .scan_code  (scan_code),
      .frame_err  (frame_err)
   );

   assign hit = decode_move(scan_code, ext_pending);

   // Prefix tracking and command generation. Prefix bytes only set their
   // flag; any other byte is looked up against the flags as they stood
   // before it and then clears both. A byte following F0 is a key release
   // and never produces a command, so typematic repeats (make codes resent
   // without a break) each yield one command. A damaged frame could have
   // been a prefix or a release, so it drops whatever prefix was pending.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ext_pending <= 1'b0;
         brk_pending <= 1'b0;
         cmd_valid   <= 1'b0;
         cmd         <= 2'd0;
      end else begin
         cmd_valid <= 1'b0;
         if (frame_err) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
         end else if (byte_valid) begin
            if (scan_code == SC_EXT) begin
               ext_pending <= 1'b1;
            end else if (scan_code == SC_BRK) begin
               brk_pending <= 1'b1;
            end else begin
               ext_pending <= 1'b0;
               brk_pending <= 1'b0;
               if (!brk_pending && hit.valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= hit.cmd;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_move_decoder
// Self-checking bench for ps2_move_decoder. Frames are driven bit by bit on
// ps2_clk/ps2_data; a keyboard-level model predicts, per system cycle, every
// pulse and held value, and a compare process checks the DUT each cycle.
// Directed sections add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ps2_move_decoder;

   localparam int TIMEOUT = 100;

   logic       clk;
   logic       resetn;
   logic       ps2_clk;
   logic       ps2_data;
   logic       byte_valid;
   logic [7:0] scan_code;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       frame_err;

   ps2_move_decoder #(
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .scan_code  (scan_code),
      .cmd_valid  (cmd_valid),
      .cmd        (cmd),
      .frame_err  (frame_err)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Expected events keyed by the cycle number at which they must be seen
   bit         exp_bv  [int];
   logic [7:0] exp_sc  [int];
   bit         exp_cv  [int];
   logic [1:0] exp_cmd [int];
   bit         exp_fe  [int];

   logic [7:0] model_sc   = 8'h00;
   logic [1:0] model_cmd  = 2'd0;
   bit         ext_m      = 1'b0;
   bit         brk_m      = 1'b0;
   bit         chk_en     = 1'b0;
   bit         skip_fe    = 1'b0;
   bit         rst_seen   = 1'b0;
   int         bv_count   = 0;
   int         cv_count   = 0;
   int         fe_count   = 0;
   int         last_cv_cyc   = 0;
   int         last_fe_cyc   = 0;
   int         last_stop_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and a record of whether the last edge applied reset
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= !resetn;
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   // Keyboard-level model of one frame whose stop-bit clock edge was driven
   // at cycle n: two synchronizer flops, one cycle of edge detect, then the
   // byte (or error) appears, and a command one cycle after that.
   task automatic modelFrame(input logic [7:0] b, input bit good, input int n);
      bit         hit;
      logic [1:0] c;
      hit = 1'b0;
      c   = 2'd0;
      if (!good) begin
         exp_fe[n+3] = 1'b1;
         ext_m = 1'b0;
         brk_m = 1'b0;
      end else begin
         exp_bv[n+3] = 1'b1;
         exp_sc[n+3] = b;
         if (b == 8'hE0) ext_m = 1'b1;
         else if (b == 8'hF0) brk_m = 1'b1;
         else begin
            if (!brk_m) begin
               if (ext_m) begin
                  if (b == 8'h6B) begin hit = 1'b1; c = 2'd0; end
                  if (b == 8'h74) begin hit = 1'b1; c = 2'd1; end
                  if (b == 8'h72) begin hit = 1'b1; c = 2'd2; end
                  if (b == 8'h75) begin hit = 1'b1; c = 2'd3; end
               end else if (b == 8'h29) begin
                  hit = 1'b1;
                  c   = 2'd3;
               end
            end
            ext_m = 1'b0;
            brk_m = 1'b0;
         end
         if (hit) begin
            exp_cv[n+4]  = 1'b1;
            exp_cmd[n+4] = c;
         end
      end
   endtask

   // Compare process: every cycle, pulses must match the model exactly and
   // the held outputs must equal the last value the model delivered.
   always @(negedge clk) begin
      bit ebv, ecv, efe;
      if (chk_en) begin
         ebv = exp_bv.exists(cyc);
         ecv = exp_cv.exists(cyc);
         efe = exp_fe.exists(cyc);
         if (rst_seen) begin
            model_sc  = 8'h00;
            model_cmd = 2'd0;
         end
         if (ebv) model_sc = exp_sc[cyc];
         if (ecv) model_cmd = exp_cmd[cyc];
         checkOutput("byte_valid", {31'd0, byte_valid}, {31'd0, ebv});
         checkOutput("cmd_valid", {31'd0, cmd_valid}, {31'd0, ecv});
         if (!skip_fe) checkOutput("frame_err", {31'd0, frame_err}, {31'd0, efe});
         checkOutput("scan_code", {24'd0, scan_code}, {24'd0, model_sc});
         checkOutput("cmd", {30'd0, cmd}, {30'd0, model_cmd});
         checkOutput("bv_fe_exclusive", {31'd0, byte_valid & frame_err}, 32'd0);
      end
      if (byte_valid === 1'b1) bv_count++;
      if (cmd_valid === 1'b1) begin cv_count++; last_cv_cyc = cyc; end
      if (frame_err === 1'b1) begin fe_count++; last_fe_cyc = cyc; end
   end

   // One PS/2 bit: data changes one cycle into the high phase, the clock
   // then falls and stays low for half cycles before returning high.
   task automatic sendBit(input logic b, input int half, output int edge_cyc);
      @(negedge clk);
      ps2_data = b;
      repeat (half - 1) @(negedge clk);
      ps2_clk  = 1'b0;
      edge_cyc = cyc;
      repeat (half) @(negedge clk);
      ps2_clk  = 1'b1;
   endtask

   // One complete frame with optional parity or stop-bit damage
   task automatic applyStimulus(input logic [7:0] b, input bit bad_par,
                                input bit bad_stop, input int half);
      logic [9:0] f;
      logic       par;
      int         e;
      par = (~^b) ^ bad_par;
      f   = {par, b, 1'b0};
      for (int i = 0; i < 10; i++) sendBit(f[i], half, e);
      @(negedge clk);
      ps2_data = ~bad_stop;
      repeat (half - 1) @(negedge clk);
      ps2_clk = 1'b0;
      modelFrame(b, !bad_par && !bad_stop, cyc);
      last_stop_cyc = cyc;
      repeat (half) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Watchdog so the run always ends
   initial begin
      repeat (95000) @(posedge clk);
      $display("[TB] FAIL watchdog actual=%0d required=<95000 cycles", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bv0, cv0, fe0, e, half, gap;
      logic [7:0] rb;
      resetn   = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      // Reset state
      checkOutput("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
      checkOutput("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
      checkOutput("rst_scan_code", {24'd0, scan_code}, 32'h00);
      checkOutput("rst_cmd", {30'd0, cmd}, 32'd0);
      chk_en = 1'b1;
      repeat (5) @(negedge clk);

      // Extended left arrow; command 4 cycles after the driven stop edge
      // (2 synchronizer cycles to detection, then 2 more)
      bv0 = bv_count; cv0 = cv_count;
      applyStimulus(8'hE0, 1'b0, 1'b0, 6);
      applyStimulus(8'h6B, 1'b0, 1'b0, 6);
      repeat (6) @(negedge clk);
      checkOutput("left_bv_count", bv_count - bv0, 32'd2);
      checkOutput("left_cv_count", cv_count - cv0, 32'd1);
      checkOutput("left_cmd", {30'd0, cmd}, 32'd0);
      checkOutput("left_scan_code", {24'd0, scan_code}, 32'h6B);
      checkOutput("left_latency", last_cv_cyc - last_stop_cyc, 32'd4);

      // Release of right arrow, then extended down
      bv0 = bv_count; cv0 = cv_count;
      applyStimulus(8'hE0, 1'b0, 1'b0, 7);
      applyStimulus(8'hF0, 1'b0, 1'b0, 7);
      applyStimulus(8'h74, 1'b0, 1'b0, 7);
      repeat (6) @(negedge clk);
      checkOutput("release_bv_count", bv_count - bv0, 32'd3);
      checkOutput("release_cv_count", cv_count - cv0, 32'd0);
      cv0 = cv_count;
      applyStimulus(8'hE0, 1'b0, 1'b0, 5);
      applyStimulus(8'h72, 1'b0, 1'b0, 5);
      repeat (6) @(negedge clk);
      checkOutput("down_cv_count", cv_count - cv0, 32'd1);
      checkOutput("down_cmd", {30'd0, cmd}, 32'd2);

      // Space with inverted parity, then a good space
      bv0 = bv_count; cv0 = cv_count; fe0 = fe_count;
      applyStimulus(8'h29, 1'b1, 1'b0, 6);
      repeat (6) @(negedge clk);
      checkOutput("badpar_fe_count", fe_count - fe0, 32'd1);
      checkOutput("badpar_bv_count", bv_count - bv0, 32'd0);
      checkOutput("badpar_scan_code", {24'd0, scan_code}, 32'h72);
      applyStimulus(8'h29, 1'b0, 1'b0, 6);
      repeat (6) @(negedge clk);
      checkOutput("space_cmd", {30'd0, cmd}, 32'd3);
      checkOutput("space_cv_count", cv_count - cv0, 32'd1);

      // Bad stop bit
      bv0 = bv_count; fe0 = fe_count;
      applyStimulus(8'h1C, 1'b0, 1'b1, 6);
      repeat (6) @(negedge clk);
      checkOutput("badstop_fe_count", fe_count - fe0, 32'd1);
      checkOutput("badstop_bv_count", bv_count - bv0, 32'd0);

      // Extended right, then a pending E0 lost to a mid-frame timeout
      applyStimulus(8'hE0, 1'b0, 1'b0, 6);
      applyStimulus(8'h74, 1'b0, 1'b0, 6);
      repeat (6) @(negedge clk);
      checkOutput("right_cmd", {30'd0, cmd}, 32'd1);
      applyStimulus(8'hE0, 1'b0, 1'b0, 6);
      fe0 = fe_count;
      skip_fe = 1'b1;
      sendBit(1'b0, 6, e);
      for (int i = 0; i < 5; i++) sendBit(i[0], 6, e);
      repeat (TIMEOUT + 20) @(negedge clk);
      skip_fe = 1'b0;
      ext_m = 1'b0;
      brk_m = 1'b0;
      checkOutput("timeout_fe_count", fe_count - fe0, 32'd1);
      checkOutput("timeout_fe_window",
                  {31'd0, (last_fe_cyc >= e + TIMEOUT) && (last_fe_cyc <= e + TIMEOUT + 6)},
                  32'd1);
      cv0 = cv_count;
      applyStimulus(8'h6B, 1'b0, 1'b0, 6);
      repeat (6) @(negedge clk);
      checkOutput("timeout_clears_ext", cv_count - cv0, 32'd0);
      applyStimulus(8'hE0, 1'b0, 1'b0, 6);
      applyStimulus(8'h75, 1'b0, 1'b0, 6);
      repeat (6) @(negedge clk);
      checkOutput("rotate_cmd", {30'd0, cmd}, 32'd3);
      checkOutput("rotate_cv_count", cv_count - cv0, 32'd1);

      // Reset in the middle of a frame
      fe0 = fe_count;
      sendBit(1'b0, 6, e);
      for (int i = 0; i < 3; i++) sendBit(1'b1, 6, e);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn   = 1'b1;
      ps2_data = 1'b1;
      ext_m = 1'b0;
      brk_m = 1'b0;
      checkOutput("midrst_byte_valid", {31'd0, byte_valid}, 32'd0);
      checkOutput("midrst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      checkOutput("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      checkOutput("midrst_scan_code", {24'd0, scan_code}, 32'h00);
      checkOutput("midrst_cmd", {30'd0, cmd}, 32'd0);
      repeat (TIMEOUT + 10) @(negedge clk);
      checkOutput("midrst_no_fe", fe_count - fe0, 32'd0);
      bv0 = bv_count; cv0 = cv_count;
      applyStimulus(8'h1C, 1'b0, 1'b0, 6);
      repeat (6) @(negedge clk);
      checkOutput("after_rst_bv_count", bv_count - bv0, 32'd1);
      checkOutput("after_rst_scan_code", {24'd0, scan_code}, 32'h1C);
      checkOutput("after_rst_cv_count", cv_count - cv0, 32'd0);

      // Random bytes at varying keyboard clock rates
      bv0 = bv_count; fe0 = fe_count;
      for (int k = 0; k < 256; k++) begin
         rb   = 8'($urandom_range(0, 255));
         half = $urandom_range(5, 8);
         gap  = $urandom_range(0, 6);
         applyStimulus(rb, 1'b0, 1'b0, half);
         repeat (gap) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      checkOutput("random_bv_count", bv_count - bv0, 32'd256);
      checkOutput("random_fe_count", fe_count - fe0, 32'd0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
